// File: rtl/sprite_pixel_fifo.sv
// Eight-entry sprite pixel FIFO: merges fetched sprite rows into the pixel slots
// under DMG/CGB priority and shifts one pixel per LCD push toward the mixer.
module sprite_pixel_fifo #(
    parameter int MAX_SPRITES = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       is_cgb,
    input  logic       line_start,
    input  logic       load,
    input  logic [7:0] tile0_in,
    input  logic [7:0] tile1_in,
    input  logic       pal_in,
    input  logic       prio_in,
    input  logic [2:0] cgb_pal_in,
    input  logic [3:0] index_in,
    input  logic       shift,
    output logic [1:0] spr_color,
    output logic       spr_pal,
    output logic       spr_prio,
    output logic [2:0] spr_cgb_pal,
    output logic [3:0] spr_index,
    output logic [3:0] sprites_loaded,
    output logic       load_dropped
);

    // Entry layout: {color[1:0], pal, prio, cgb_pal[2:0], index[3:0]}
    localparam logic [10:0] EMPTY = 11'h00F;

    logic [10:0] fifo_q   [8];
    logic [10:0] shifted  [8];
    logic [10:0] fifo_d   [8];
    logic [1:0]  new_color[8];
    logic [3:0]  cnt_q;
    logic        saturated;
    logic        accept;

    // load is a strobe with no back-pressure: every ce-qualified load is either
    // merged (accept) or discarded (load_dropped) in the cycle it is presented.
    assign saturated    = (cnt_q >= 4'(MAX_SPRITES));
    assign accept       = ce & load & ~line_start & ~saturated;
    assign load_dropped = ce & load & ~line_start & saturated;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            shifted[k] = fifo_q[k];
        end
        if (shift) begin
            for (int k = 0; k < 7; k++) begin
                shifted[k] = fifo_q[k+1];
            end
            shifted[7] = EMPTY;
        end
        // Merge sees the post-shift contents, so new pixel i lands in slot i.
        for (int i = 0; i < 8; i++) begin
            new_color[i] = {tile1_in[7-i], tile0_in[7-i]};
            fifo_d[i]    = shifted[i];
            if (accept && new_color[i] != 2'd0 &&
                (shifted[i][10:9] == 2'd0 ||
                 (is_cgb && index_in < shifted[i][3:0]))) begin
                fifo_d[i] = {new_color[i], pal_in, prio_in, cgb_pal_in, index_in};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 8; k++) begin
                fifo_q[k] <= EMPTY;
            end
            cnt_q <= 4'd0;
        end else if (ce) begin
            if (line_start) begin
                for (int k = 0; k < 8; k++) begin
                    fifo_q[k] <= EMPTY;
                end
                cnt_q <= 4'd0;
            end else begin
                for (int k = 0; k < 8; k++) begin
                    fifo_q[k] <= fifo_d[k];
                end
                if (accept) begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end
        end
    end

    assign spr_color      = fifo_q[0][10:9];
    assign spr_pal        = fifo_q[0][8];
    assign spr_prio       = fifo_q[0][7];
    assign spr_cgb_pal    = fifo_q[0][6:4];
    assign spr_index      = fifo_q[0][3:0];
    assign sprites_loaded = cnt_q;

endmodule

// File: tb/tb_sprite_pixel_fifo.sv
// Bench for sprite_pixel_fifo: directed scenarios plus random traffic against
// a per-pixel array model of the FIFO.
module tb_sprite_pixel_fifo;

    localparam int MAX_SPR = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce = 1'b0;
    logic       is_cgb = 1'b0;
    logic       line_start = 1'b0;
    logic       load = 1'b0;
    logic [7:0] tile0_in = 8'h00;
    logic [7:0] tile1_in = 8'h00;
    logic       pal_in = 1'b0;
    logic       prio_in = 1'b0;
    logic [2:0] cgb_pal_in = 3'd0;
    logic [3:0] index_in = 4'd0;
    logic       shift = 1'b0;
    logic [1:0] spr_color;
    logic       spr_pal;
    logic       spr_prio;
    logic [2:0] spr_cgb_pal;
    logic [3:0] spr_index;
    logic [3:0] sprites_loaded;
    logic       load_dropped;

    sprite_pixel_fifo #(.MAX_SPRITES(MAX_SPR)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .is_cgb(is_cgb),
        .line_start(line_start), .load(load), .tile0_in(tile0_in),
        .tile1_in(tile1_in), .pal_in(pal_in), .prio_in(prio_in),
        .cgb_pal_in(cgb_pal_in), .index_in(index_in), .shift(shift),
        .spr_color(spr_color), .spr_pal(spr_pal), .spr_prio(spr_prio),
        .spr_cgb_pal(spr_cgb_pal), .spr_index(spr_index),
        .sprites_loaded(sprites_loaded), .load_dropped(load_dropped)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [10:0] exp_q[$];
    logic last_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_col[8], m_pal[8], m_prio[8], m_cpal[8], m_idx[8];
    int m_cnt;

    task automatic model_clear();
        for (int k = 0; k < 8; k++) begin
            m_col[k] = 0; m_pal[k] = 0; m_prio[k] = 0; m_cpal[k] = 0; m_idx[k] = 15;
        end
        m_cnt = 0;
    endtask

    // Applies one clock edge's worth of behaviour; returns whether a load was dropped.
    task automatic model_step(output logic dropped);
        int c;
        dropped = 1'b0;
        if (!ce) return;
        if (line_start) begin
            model_clear();
            return;
        end
        if (shift) begin
            for (int k = 0; k < 7; k++) begin
                m_col[k] = m_col[k+1]; m_pal[k] = m_pal[k+1]; m_prio[k] = m_prio[k+1];
                m_cpal[k] = m_cpal[k+1]; m_idx[k] = m_idx[k+1];
            end
            m_col[7] = 0; m_pal[7] = 0; m_prio[7] = 0; m_cpal[7] = 0; m_idx[7] = 15;
        end
        if (load) begin
            if (m_cnt == MAX_SPR) begin
                dropped = 1'b1;
            end else begin
                m_cnt++;
                for (int i = 0; i < 8; i++) begin
                    c = 2 * int'(tile1_in[7-i]) + int'(tile0_in[7-i]);
                    if (c != 0 && (m_col[i] == 0 || (is_cgb && int'(index_in) < m_idx[i]))) begin
                        m_col[i] = c; m_pal[i] = int'(pal_in); m_prio[i] = int'(prio_in);
                        m_cpal[i] = int'(cgb_pal_in); m_idx[i] = int'(index_in);
                    end
                end
            end
        end
    endtask

    function automatic logic [10:0] model_head();
        return {m_col[0][1:0], m_pal[0][0], m_prio[0][0], m_cpal[0][2:0], m_idx[0][3:0]};
    endfunction

    // ---------------- driver ----------------
    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic cycle(input logic c_ce, input logic c_ls, input logic c_ld, input logic c_sh,
                         input logic [7:0] t0, input logic [7:0] t1, input logic c_pal,
                         input logic c_prio, input logic [2:0] c_cpal, input logic [3:0] c_idx);
        logic exp_drop;
        ce = c_ce; line_start = c_ls; load = c_ld; shift = c_sh;
        tile0_in = t0; tile1_in = t1; pal_in = c_pal; prio_in = c_prio;
        cgb_pal_in = c_cpal; index_in = c_idx;
        #1;
        model_step(exp_drop);
        check("load_dropped", 32'(load_dropped), 32'(exp_drop));
        last_drop = load_dropped;
        @(posedge clk);
        #1;
        exp_q.push_back(model_head());
        check("head", 32'({spr_color, spr_pal, spr_prio, spr_cgb_pal, spr_index}), 32'(exp_q.pop_front()));
        check("sprites_loaded", 32'(sprites_loaded), 32'(m_cnt));
    endtask

    task automatic do_load(input logic [7:0] t0, input logic [7:0] t1, input logic p, input logic [3:0] idx);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, t0, t1, p, 1'b0, 3'd0, idx);
    endtask

    task automatic do_shift(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 4'd0);
    endtask

    task automatic do_line_start();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 4'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_clear();
        #12;
        check("rst_color", 32'(spr_color), 32'd0);
        check("rst_index", 32'(spr_index), 32'hF);
        check("rst_loaded", 32'(sprites_loaded), 32'd0);
        check("rst_dropped", 32'(load_dropped), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single load then drain.
        do_load(8'hFF, 8'h00, 1'b1, 4'd0);
        check("t1_color", 32'(spr_color), 32'd1);
        check("t1_pal", 32'(spr_pal), 32'd1);
        do_shift(8);
        check("t1_drain_color", 32'(spr_color), 32'd0);
        check("t1_drain_index", 32'(spr_index), 32'hF);

        // DMG overlap.
        do_line_start();
        do_load(8'hF0, 8'h00, 1'b0, 4'd3);
        do_load(8'hFF, 8'hFF, 1'b0, 4'd1);
        check("dmg_p0_color", 32'(spr_color), 32'd1);
        check("dmg_p0_index", 32'(spr_index), 32'd3);
        do_shift(4);
        check("dmg_p4_color", 32'(spr_color), 32'd3);
        check("dmg_p4_index", 32'(spr_index), 32'd1);

        // CGB overlap, then a lower-priority sprite that must not win.
        is_cgb = 1'b1;
        do_line_start();
        do_load(8'hF0, 8'h00, 1'b0, 4'd3);
        do_load(8'hFF, 8'hFF, 1'b0, 4'd1);
        check("cgb_p0_color", 32'(spr_color), 32'd3);
        check("cgb_p0_index", 32'(spr_index), 32'd1);
        do_load(8'hFF, 8'h00, 1'b1, 4'd5);
        check("cgb_lowprio_index", 32'(spr_index), 32'd1);
        do_shift(7);
        check("cgb_p7_index", 32'(spr_index), 32'd1);

        // Simultaneous load and shift (DMG).
        is_cgb = 1'b0;
        do_line_start();
        do_load(8'h00, 8'h40, 1'b0, 4'd2);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 3'd0, 4'd4);
        check("ls_head_color", 32'(spr_color), 32'd2);
        do_shift(7);
        check("ls_e7_color", 32'(spr_color), 32'd1);

        // Saturation: eleven loads, the last one dropped.
        do_line_start();
        for (int n = 0; n < 10; n++) do_load(8'h00, 8'h00, 1'b0, 4'(n));
        do_load(8'hFF, 8'hFF, 1'b1, 4'd0);
        check("sat_loaded", 32'(sprites_loaded), 32'd10);
        check("sat_drop_pulse", 32'(last_drop), 32'd1);
        check("sat_fifo_untouched", 32'(spr_color), 32'd0);
        do_shift(1);
        check("sat_drop_cleared", 32'(load_dropped), 32'd0);
        do_line_start();
        check("sat_cleared", 32'(sprites_loaded), 32'd0);

        // ce=0 freezes everything.
        do_load(8'hAA, 8'h55, 1'b1, 4'd6);
        for (int n = 0; n < 4; n++) cycle(1'b0, n[0], 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 3'd7, 4'd0);
        check("ce0_color", 32'(spr_color), 32'd1);
        check("ce0_index", 32'(spr_index), 32'd6);

        // Asynchronous reset mid-cycle with a populated FIFO.
        do_load(8'hFF, 8'hFF, 1'b1, 4'd2);
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        check("arst_color", 32'(spr_color), 32'd0);
        check("arst_pal", 32'(spr_pal), 32'd0);
        check("arst_index", 32'(spr_index), 32'hF);
        check("arst_loaded", 32'(sprites_loaded), 32'd0);
        ce = 1'b0; load = 1'b0; shift = 1'b0; line_start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) < 3) is_cgb = 1'(~is_cgb);
            cycle(1'($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 59) == 0),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)),
                  8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  3'($urandom), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
